seq_alu: RTL and testbench

Parametrised, pipelined successor to the team's 5-bit combinational ALU. It accepts operand pairs through a valid/ready handshake and returns registered results with carry, overflow and zero flags through a one-entry output register. It adds a multi-cycle unsigned multiply (shift-add) alongside the single-cycle add, subtract, logic and shift operations. It sits between the operand source and the result consumer in the datapath lab designs.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_if.sv | 33 +++
 rtl/seq_alu_mul_seq.sv | 62 ++++++
 rtl/seq_alu.sv | 170 +++++++++++++++++
 tb/tb_seq_alu.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   op_t      - 3-bit operation codes accepted on the op input
//   state_t   - control FSM states (IDLE, MUL)
//   cnt_width - width of the multiply iteration counter for a given W
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Counter must hold W-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w > 2) begin
      return $clog2(w);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle of seq_alu.
//   in_valid/in_ready, op, x, y, cin   - operand channel (source -> ALU)
//   out_valid/out_ready, f, f_hi,
//   cout, ovf, zero                    - result channel (ALU -> consumer)
// Modports: master = operand source / result consumer, slave = the ALU.
interface seq_alu_if #(parameter int W = 5);
  import seq_alu_pkg::*;

  logic         in_valid;
  logic         in_ready;
  op_t          op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic [W-1:0] f_hi;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, op, x, y, cin, out_ready,
    input  in_ready, out_valid, f, f_hi, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op, x, y, cin, out_ready,
    output in_ready, out_valid, f, f_hi, cout, ovf, zero
  );

endinterface

// File: rtl/seq_alu_mul_seq.sv
// alu_mul_seq: W-iteration shift-add unsigned multiplier.
//   clk, rst_n - clock, async active-low reset (aborts a running multiply)
//   start      - load x (multiplicand) and y (multiplier), begin iterating
//   x, y       - operands, sampled only on start
//   done       - high in the cycle whose closing edge performs the last iteration
//   product    - value the accumulator takes at that edge (valid while done)
module alu_mul_seq
  import seq_alu_pkg::*;
#(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = cnt_width(W);

  logic [W-1:0]  mcand_r;
  logic [2*W:0]  acc_r;      // {carry, partial product high half, multiplier/low half}
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic [W:0]    added_s;
  logic [2*W:0]  acc_nxt_s;

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole register right.
  always_comb begin
    added_s   = acc_r[2*W:W] + (acc_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    acc_nxt_s = {1'b0, added_s, acc_r[W-1:1]};
  end

  assign done    = busy_r && (cnt_r == {CW{1'b0}});
  assign product = acc_nxt_s[2*W-1:0];

  // Operand load on start, then one iteration per cycle counting down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= {W{1'b0}};
      acc_r   <= {(2*W+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
    end else if (start) begin
      mcand_r <= x;
      acc_r   <= {{(W+1){1'b0}}, y};
      cnt_r   <= CW'(W - 1);
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      acc_r <= acc_nxt_s;
      if (cnt_r == {CW{1'b0}}) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: pipelined ALU with a one-entry registered result and a
// multi-cycle shift-add multiply.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_alu_if.slave: operand handshake in, registered result out
//           (f, f_hi, cout, ovf, zero, out_valid)
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  state_t         state_r, state_nxt_s;
  logic [W-1:0]   f_r, f_nxt_s;
  logic [W-1:0]   f_hi_r, f_hi_nxt_s;
  logic           cout_r, cout_nxt_s;
  logic           ovf_r, ovf_nxt_s;
  logic           zero_r, zero_nxt_s;
  logic           out_valid_r, out_valid_nxt_s;

  logic           in_ready_s;
  logic           accept_s;
  logic           mul_start_s;
  logic           mul_done_s;
  logic [2*W-1:0] product_s;

  logic [W-1:0]   b_s;
  logic [W:0]     sum_s;
  logic [W-1:0]   alu_f_s;
  logic           alu_cout_s;
  logic           alu_ovf_s;

  // New operands are taken only in IDLE when the result slot is free or
  // is being drained on this same edge.
  assign in_ready_s = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .x       (bus.x),
    .y       (bus.y),
    .done    (mul_done_s),
    .product (product_s)
  );

  // Single-cycle ops; SUB shares the adder with y inverted.
  always_comb begin
    b_s        = (bus.op == OP_SUB) ? ~bus.y : bus.y;
    sum_s      = {1'b0, bus.x} + {1'b0, b_s} + {{W{1'b0}}, bus.cin};
    alu_f_s    = {W{1'b0}};
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        alu_f_s    = sum_s[W-1:0];
        alu_cout_s = sum_s[W];
        // Overflow: effective operands share a sign the sum does not.
        alu_ovf_s  = (bus.x[W-1] == b_s[W-1]) && (sum_s[W-1] != bus.x[W-1]);
      end
      OP_AND:  alu_f_s = bus.x & bus.y;
      OP_OR:   alu_f_s = bus.x | bus.y;
      OP_XOR:  alu_f_s = bus.x ^ bus.y;
      OP_SHL: begin
        alu_f_s    = {bus.x[W-2:0], bus.cin};
        alu_cout_s = bus.x[W-1];
      end
      OP_SHR: begin
        alu_f_s    = {bus.cin, bus.x[W-1:1]};
        alu_cout_s = bus.x[0];
      end
      default: begin
        alu_f_s    = {W{1'b0}};
        alu_cout_s = 1'b0;
      end
    endcase
  end

  // FSM next state and result-register next values.
  always_comb begin
    state_nxt_s     = state_r;
    f_nxt_s         = f_r;
    f_hi_nxt_s      = f_hi_r;
    cout_nxt_s      = cout_r;
    ovf_nxt_s       = ovf_r;
    zero_nxt_s      = zero_r;
    out_valid_nxt_s = out_valid_r;
    mul_start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (bus.op == OP_MUL) begin
            // Old result (if any) is drained on this edge; slot stays empty
            // until the product lands.
            mul_start_s     = 1'b1;
            out_valid_nxt_s = 1'b0;
            state_nxt_s     = MUL;
          end else begin
            f_nxt_s         = alu_f_s;
            f_hi_nxt_s      = {W{1'b0}};
            cout_nxt_s      = alu_cout_s;
            ovf_nxt_s       = alu_ovf_s;
            zero_nxt_s      = ~|alu_f_s;
            out_valid_nxt_s = 1'b1;
          end
        end else if (out_valid_r && bus.out_ready) begin
          out_valid_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = out_valid_r;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          f_nxt_s         = product_s[W-1:0];
          f_hi_nxt_s      = product_s[2*W-1:W];
          cout_nxt_s      = |product_s[2*W-1:W];
          ovf_nxt_s       = 1'b0;
          zero_nxt_s      = ~|product_s;
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = MUL;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result register: all flags move together with f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_r         <= {W{1'b0}};
      f_hi_r      <= {W{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      f_r         <= f_nxt_s;
      f_hi_r      <= f_hi_nxt_s;
      cout_r      <= cout_nxt_s;
      ovf_r       <= ovf_nxt_s;
      zero_r      <= zero_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.f         = f_r;
  assign bus.f_hi      = f_hi_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W  = 5;
  localparam int W8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   rnd_done = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_alu_if #(.W(W))  bus  ();
  seq_alu_if #(.W(W8)) bus8 ();

  seq_alu #(.W(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  seq_alu #(.W(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int f;
    int fhi;
    int cout;
    int ovf;
    int zero;
  } res_t;

  function automatic int as_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic res_t ref_op(input op_t op, input int x, input int y, input int cin);
    res_t r;
    int   mask, half, s, ss, ny, p;
    mask = (1 << W) - 1;
    half = 1 << (W - 1);
    r = '{default: 0};
    case (op)
      OP_ADD, OP_SUB: begin
        ny     = (op == OP_SUB) ? mask - y : y;
        s      = x + ny + cin;
        r.f    = s & mask;
        r.cout = (s > mask) ? 1 : 0;
        ss     = as_signed(x) + as_signed(ny) + cin;
        r.ovf  = (ss > half - 1 || ss < -half) ? 1 : 0;
      end
      OP_AND: r.f = x & y;
      OP_OR:  r.f = x | y;
      OP_XOR: r.f = x ^ y;
      OP_SHL: begin
        r.f    = ((x * 2) + cin) & mask;
        r.cout = (x >= half) ? 1 : 0;
      end
      OP_SHR: begin
        r.f    = (x / 2) + cin * half;
        r.cout = x % 2;
      end
      default: begin
        p      = x * y;
        r.f    = p & mask;
        r.fhi  = p >> W;
        r.cout = (r.fhi != 0) ? 1 : 0;
      end
    endcase
    r.zero = (r.f == 0 && r.fhi == 0) ? 1 : 0;
    return r;
  endfunction

  res_t m_res  = '{default: 0};
  res_t m_pend = '{default: 0};
  bit   m_valid = 1'b0;
  int   m_mul_left = 0;   // cycles until a pending product lands
  wire  m_rdy = (m_mul_left == 0) && (!m_valid || bus.out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res      <= '{default: 0};
      m_pend     <= '{default: 0};
      m_valid    <= 1'b0;
      m_mul_left <= 0;
    end else if (m_mul_left > 0) begin
      m_mul_left <= m_mul_left - 1;
      if (m_mul_left == 1) begin
        m_res   <= m_pend;
        m_valid <= 1'b1;
      end
    end else if (bus.in_valid && m_rdy) begin
      if (bus.op == OP_MUL) begin
        m_pend     <= ref_op(bus.op, int'(bus.x), int'(bus.y), int'(bus.cin));
        m_mul_left <= W;
        m_valid    <= 1'b0;
      end else begin
        m_res   <= ref_op(bus.op, int'(bus.x), int'(bus.y), int'(bus.cin));
        m_valid <= 1'b1;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_in_ready",  bus.in_ready,  m_rdy);
    chk("m_out_valid", bus.out_valid, m_valid);
    chk("m_f",         bus.f,         m_res.f);
    chk("m_f_hi",      bus.f_hi,      m_res.fhi);
    chk("m_cout",      bus.cout,      m_res.cout);
    chk("m_ovf",       bus.ovf,       m_res.ovf);
    chk("m_zero",      bus.zero,      m_res.zero);
  end

  // ---------------- stimulus helpers ----------------
  // Call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input op_t op, input int x, input int y, input int cin, output int acc_cyc);
    bit rdy;
    int n;
    bus.op       = op;
    bus.x        = W'(x);
    bus.y        = W'(y);
    bus.cin      = cin[0];
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int a, c0, c1, c2, c3, n;
    bus.in_valid = 1'b0; bus.op = OP_ADD; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = OP_ADD; bus8.x = '0; bus8.y = '0; bus8.cin = 1'b0;
    bus8.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_f",         bus.f,         0);
    align();

    send(OP_ADD, 6, 7, 0, a);
    @(negedge clk);
    chk("add_valid", bus.out_valid, 1);
    chk("add_f", bus.f, 13);
    chk("add_cout", bus.cout, 0);
    chk("add_ovf", bus.ovf, 0);
    chk("add_zero", bus.zero, 0);
    align();
    send(OP_ADD, 15, 1, 0, a);
    @(negedge clk);
    chk("addovf_f", bus.f, 16);
    chk("addovf_ovf", bus.ovf, 1);
    chk("addovf_cout", bus.cout, 0);
    align();
    send(OP_SUB, 17, 7, 1, a);
    @(negedge clk);
    chk("sub1_f", bus.f, 10);
    chk("sub1_cout", bus.cout, 1);
    align();
    send(OP_SUB, 3, 7, 1, a);
    @(negedge clk);
    chk("sub2_f", bus.f, 28);
    chk("sub2_cout", bus.cout, 0);
    align();
    send(OP_SHL, 22, 0, 1, a);
    @(negedge clk);
    chk("shl_f", bus.f, 13);
    chk("shl_cout", bus.cout, 1);
    align();
    send(OP_SHR, 22, 0, 0, a);
    @(negedge clk);
    chk("shr_f", bus.f, 11);
    chk("shr_cout", bus.cout, 0);
    align();
    send(OP_XOR, 9, 9, 1, a);
    @(negedge clk);
    chk("xor_zero", bus.zero, 1);
    chk("xor_cout", bus.cout, 0);
    chk("xor_ovf", bus.ovf, 0);
    align();
    send(OP_AND, 12, 10, 1, a);
    @(negedge clk);
    chk("and_f", bus.f, 8);
    chk("and_cout", bus.cout, 0);
    align();
    send(OP_OR, 12, 10, 1, a);
    @(negedge clk);
    chk("or_f", bus.f, 14);
    align();

    // MUL 31*31: result one cycle after the W in-MUL cycles.
    send(OP_MUL, 31, 31, 0, a);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.out_valid || n >= 50) break;
      chk("mul_in_ready", bus.in_ready, 0);
    end
    chk("mul_latency", n, W + 1);
    chk("mul_f_hi", bus.f_hi, 30);
    chk("mul_f", bus.f, 1);
    chk("mul_cout", bus.cout, 1);
    align();

    // Backpressure with three ops offered.
    send(OP_ADD, 1, 2, 0, a);
    bus.out_ready = 1'b0;
    bus.op = OP_ADD; bus.x = 5'd4; bus.y = 5'd4; bus.cin = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_f", bus.f, 3);
    end
    align();
    bus.out_ready = 1'b1;
    align();
    bus.x = 5'd5; bus.y = 5'd5;
    @(negedge clk);
    chk("bp_second", bus.f, 8);
    align();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third", bus.f, 10);
    align();

    send(OP_ADD, 1, 1, 0, c0);
    send(OP_ADD, 2, 3, 0, c1);
    send(OP_ADD, 4, 5, 0, c2);
    send(OP_ADD, 8, 9, 1, c3);
    chk("b2b_cycles", c3 - c0, 3);

    // Reset two cycles into a MUL.
    send(OP_MUL, 7, 9, 0, a);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmul_valid", bus.out_valid, 0);
    chk("rmul_f", bus.f, 0);
    chk("rmul_f_hi", bus.f_hi, 0);
    chk("rmul_cout", bus.cout, 0);
    chk("rmul_ovf", bus.ovf, 0);
    chk("rmul_zero", bus.zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rmul_no_valid", bus.out_valid, 0);
    end
    align();
    send(OP_ADD, 1, 1, 0, a);
    @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_f", bus.f, 2);
    align();

    // Random traffic with random backpressure.
    fork
      begin
        int g;
        repeat (300) begin
          g = $urandom_range(0, 2);
          repeat (g) align();
          send(op_t'($urandom_range(0, 7)), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 1), a);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          align();
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    align();
    bus.out_ready = 1'b1;
    repeat (10) align();

    // W=8 instance: 255*255.
    bus8.op = OP_MUL; bus8.x = 8'hFF; bus8.y = 8'hFF; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
    @(negedge clk);
    chk("mul8_in_ready", bus8.in_ready, 1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus8.out_valid || n >= 50) break;
      chk("mul8_in_ready_low", bus8.in_ready, 0);
    end
    chk("mul8_latency", n, W8 + 1);
    chk("mul8_f_hi", bus8.f_hi, 8'hFE);
    chk("mul8_f", bus8.f, 8'h01);
    chk("mul8_cout", bus8.cout, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
